pipe_hazard_ctrl: RTL

//  Central stall/flush/forward controller for the 5-stage pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline, with a data-memory freeze FSM and a stall counter.
// Optional feature macro: PIPE_FWD_EN (EX operand forwarding; otherwise RAW hazards stall until writeback).
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             reloj,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd_rt,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd_rt,
    input  logic             wb_regwrite,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             en_if_id,
    output logic             en_id_ex,
    output logic             en_ex_mem,
    output logic             en_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WW = $clog2(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          freeze;
    logic          err_set;
    logic          load_use;
    logic          data_stall;
    logic          stall_inc;
    logic [1:0]    fwd_a_raw, fwd_b_raw;

    function automatic logic id_reads(input logic [4:0] dest);
        return (dest != 5'd0) &&
               ((dest == id_rs) || (id_uses_rt && (dest == id_rt)));
    endfunction

    // The last timed-out wait cycle is still frozen; the release happens on the following cycle.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        freeze    = 1'b0;
        err_set   = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                        err_set   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + WW'(1);
                    end
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    assign load_use = ex_memread && ex_regwrite && id_reads(ex_rd_rt);

`ifdef PIPE_FWD_EN
    assign data_stall = load_use;

    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (ex_rs != 5'd0) begin
            if (mem_regwrite && (mem_rd_rt == ex_rs))
                fwd_a_raw = 2'b10;
            else if (wb_regwrite && (wb_rd_rt == ex_rs))
                fwd_a_raw = 2'b01;
        end
        if (ex_rt != 5'd0) begin
            if (mem_regwrite && (mem_rd_rt == ex_rt))
                fwd_b_raw = 2'b10;
            else if (wb_regwrite && (wb_rd_rt == ex_rt))
                fwd_b_raw = 2'b01;
        end
    end
`else
    logic unused_fwd_inputs;

    // WB needs no stall: the register file writes in the first half-cycle.
    assign data_stall = load_use ||
                        (ex_regwrite && id_reads(ex_rd_rt)) ||
                        (mem_regwrite && id_reads(mem_rd_rt));
    assign fwd_a_raw  = 2'b00;
    assign fwd_b_raw  = 2'b00;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd_rt, wb_regwrite};
`endif

    assign stall_inc = freeze || (!ex_branch_taken && data_stall);

    always_comb begin
        pc_en       = 1'b1;
        en_if_id    = 1'b1;
        en_id_ex    = 1'b1;
        en_ex_mem   = 1'b1;
        en_mem_wb   = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        fwd_a       = fwd_a_raw;
        fwd_b       = fwd_b_raw;
        if (!reset_n) begin
            pc_en       = 1'b0;
            en_if_id    = 1'b0;
            en_id_ex    = 1'b0;
            en_ex_mem   = 1'b0;
            en_mem_wb   = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
        end else if (freeze) begin
            pc_en     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end else if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (data_stall) begin
            pc_en       = 1'b0;
            en_if_id    = 1'b0;
            flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set)
                mem_err <= 1'b1;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
